// File: rtl/bp_pkg.sv
// Shared types and counter encodings for the BTB branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    JMP  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } br_type_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack: push when full overwrites the oldest entry,
// pop when empty does nothing.
module bp_ras
  import bp_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next write slot; the top is the slot just below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = stack_q[top_idx];
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) stack_q[i] <= '0;
    end else if (push_i) begin
      stack_q[ptr_q] <= push_data_i;
      ptr_q          <= ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters, mispredict redirect and
// saturating performance counters. Return-address stack enabled by BP_RAS_EN.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            hit_o,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] predicted_pc_o,
  input  logic            update_valid_i,
  input  logic [PC_W-1:0] update_pc_i,
  input  logic [1:0]      update_type_i,
  input  logic            update_taken_i,
  input  logic [PC_W-1:0] update_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [PC_W-1:0] ex_pred_pc_i,
  output logic            mispredict_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic [31:0]     no_branch_o,
  output logic [31:0]     no_mispredict_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 ||
      RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("branch_predictor_btb: ENTRIES and RAS_DEPTH must be powers of two >= 2");
  end

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  br_type_e           type_q   [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [31:0]        no_branch_q;
  logic [31:0]        no_mispredict_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [PC_W-1:0]  lk_target;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  br_type_e         up_type;
  logic [PC_W-1:0]  up_pc_plus4;

  assign lk_idx      = pc_i[IDX_W+1:2];
  assign lk_tag      = pc_i[PC_W-1:IDX_W+2];
  assign up_idx      = update_pc_i[IDX_W+1:2];
  assign up_tag      = update_pc_i[PC_W-1:IDX_W+2];
  assign up_type     = br_type_e'(update_type_i);
  assign up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_pc_plus4 = update_pc_i + PC_W'(4);

`ifdef BP_RAS_EN
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;

  bp_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (update_valid_i && up_type == CALL),
    .pop_i       (update_valid_i && up_type == RET),
    .push_data_i (up_pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  // A RET entry follows the stack while it holds anything.
  assign lk_target = (type_q[lk_idx] == RET && !ras_empty) ? ras_top : target_q[lk_idx];
`else
  assign lk_target = target_q[lk_idx];
`endif

  // Fetch-side lookup; no bypass from a same-cycle update.
  always_comb begin
    hit_o          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o   = hit_o && (ctr_q[lk_idx][1] || type_q[lk_idx] != BR);
    predicted_pc_o = pred_taken_o ? lk_target : pc_i + PC_W'(4);
  end

  // EX-side resolution check.
  always_comb begin
    mispredict_o  = update_valid_i &&
                    ((update_taken_i != ex_pred_taken_i) ||
                     (update_taken_i && update_target_i != ex_pred_pc_i));
    redirect_pc_o = '0;
    if (update_valid_i) redirect_pc_o = update_taken_i ? update_target_i : up_pc_plus4;
  end

  // Training: hits adapt in place, taken misses allocate, not-taken misses are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        type_q[i]   <= BR;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (update_valid_i) begin
      if (up_hit) begin
        ctr_q[up_idx]  <= (up_type == BR) ? ctr_next(ctr_q[up_idx], update_taken_i) : CTR_ST;
        type_q[up_idx] <= up_type;
        if (update_taken_i) target_q[up_idx] <= update_target_i;
      end else if (update_taken_i) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target_i;
        type_q[up_idx]   <= up_type;
        ctr_q[up_idx]    <= (up_type == BR) ? CTR_WT : CTR_ST;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      no_branch_q     <= '0;
      no_mispredict_q <= '0;
    end else begin
      if (update_valid_i && no_branch_q != '1) no_branch_q <= no_branch_q + 32'd1;
      if (mispredict_o && no_mispredict_q != '1) no_mispredict_q <= no_mispredict_q + 32'd1;
    end
  end

  assign no_branch_o     = no_branch_q;
  assign no_mispredict_o = no_mispredict_q;

endmodule
